pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage CPU pipeline. Drives hold/flush controls of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards between ID and EX.
- Squashes wrong-path instructions on control-flow redirects resolved in EX.
- Freezes the pipeline while a game-peripheral special op (getRow/sendRow/moveOrWriteShape) completes a req/ack handshake, with a timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for periph_ack before abort; range 1..65535.
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1  in  5  ID source reg 1
- id_rs2  in  5  ID source reg 2
- id_uses_rs1  in  1  ID instr reads rs1
- id_uses_rs2  in  1  ID instr reads rs2
- ex_writeregsel  in  5  EX destination reg
- ex_memRead  in  1  EX instr is a load
- ex_redirect  in  1  EX resolved taken branch/J/JAL/return
- ex_special  in  1  EX instr is getRow/sendRow/moveOrWriteShape
- periph_ack  in  1  peripheral completion, single-cycle pulse
- pc_hold  out  1  PC keeps value
- ifid_hold  out  1  IF/ID keeps value
- ifid_flush  out  1  IF/ID zeroed
- idex_hold  out  1  ID/EX keeps value
- idex_flush  out  1  ID/EX outputs forced to 0 (bubble)
- periph_req  out  1  level request to peripheral
- periph_err  out  1  sticky timeout flag
- busy  out  1  FSM not IDLE

Behaviour:
- All outputs combinational from FSM state and inputs. Reset value of every output is 0. State resets to IDLE; timeout counter and periph_err reset to 0.
- Load-use: luh = ex_memRead & (ex_writeregsel != 0) & ((id_uses_rs1 & id_rs1 == ex_writeregsel) | (id_uses_rs2 & id_rs2 == ex_writeregsel)). Register x0 never causes a hazard.
- FSM states: IDLE, WAIT_ACK, DRAIN.
- IDLE, priority redirect > special > load-use:
  - ex_redirect: ifid_flush=1 and idex_flush=1 the same cycle; no holds. A concurrent luh is ignored.
  - else ex_special: periph_req=1, pc_hold=ifid_hold=idex_hold=1; next state WAIT_ACK; counter cleared.
  - else luh: pc_hold=ifid_hold=1, idex_flush=1 for one cycle (1-cycle bubble).
- WAIT_ACK:
  - periph_req=1 and all three holds asserted.
  - periph_ack: next state DRAIN.
  - else counter increments. When counter == TIMEOUT_CYCLES-1 with no ack: periph_err<=1, next state DRAIN.
  - Redirect and luh are not evaluated in this state.
- DRAIN: one cycle. periph_req=0, holds released, idex_flush=1 so the special op is not re-issued. Next state IDLE.
- periph_ack outside WAIT_ACK is ignored.
- periph_err clears only on reset.
- Counter is CNT_W bits wide and never wraps: the timeout fires first.
- Reset mid-operation: periph_req drops asynchronously and the FSM returns to IDLE.
- Special op and redirect in the same EX cycle is illegal (decoder guarantees exclusivity). Redirect wins if it occurs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt [31:0] (cycles with pc_hold=1) and perf_flush_cnt [31:0] (cycles with ifid_flush or idex_flush).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - hz_state_e enum {IDLE, WAIT_ACK, DRAIN}
  - REG_ZERO = 5'd0
  - DEFAULT_PERIPH_TIMEOUT = 255
- Sub-module hz_loaduse_detect: purely combinational luh comparator, reusable for future forwarding logic.

Test Plan:
- Load x5 in EX, ID add reads rs1=5 -> one cycle pc_hold=ifid_hold=1, idex_flush=1; next cycle all 0.
- Load to x0 in EX, ID reads rs1=0 -> no hold, no flush.
- ex_redirect=1 with concurrent luh -> ifid_flush=idex_flush=1, pc_hold=0, single cycle.
- ex_special=1, ack 4 cycles later -> periph_req high exactly 5 cycles, holds 5 cycles, one DRAIN cycle with idex_flush=1, then IDLE; periph_err=0.
- TIMEOUT_CYCLES=8, no ack -> periph_err=1 after 8 WAIT_ACK cycles, DRAIN, IDLE; stray ack later ignored.
- rst low during WAIT_ACK -> all outputs 0 immediately; after release FSM in IDLE, periph_err=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline control blocks.
package cpu_ctrl_pkg;

    localparam int unsigned REG_W                  = 5;
    localparam int unsigned DEFAULT_CNT_W          = 16;
    localparam int unsigned DEFAULT_PERIPH_TIMEOUT = 255;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DRAIN    = 2'd2
    } hz_state_e;

    // Pipeline control bundle driven by the hazard sequencer.
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_hold;
        logic idex_flush;
        logic periph_req;
    } hz_ctrl_t;

endpackage

// File: rtl/hz_loaduse_detect.sv
// Combinational load-use comparator between the ID and EX stages.
// x0 is never a hazard source since it is hard-wired to zero.
module hz_loaduse_detect
    import cpu_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [REG_W-1:0] ex_writeregsel_i,
    input  logic             ex_mem_read_i,
    output logic             luh_o
);

    // Flag an ID read of the register an in-flight load is about to write.
    always_comb begin
        luh_o = 1'b0;
        if (ex_mem_read_i && (ex_writeregsel_i != REG_ZERO)) begin
            luh_o = (id_uses_rs1_i && (id_rs1_i == ex_writeregsel_i)) ||
                    (id_uses_rs2_i && (id_rs2_i == ex_writeregsel_i));
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// redirect squashing and freezing during peripheral special ops.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_PERIPH_TIMEOUT,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_writeregsel,
    input  logic             ex_memRead,
    input  logic             ex_redirect,
    input  logic             ex_special,
    input  logic             periph_ack,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             periph_req,
    output logic             periph_err,
    output logic             busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             luh;
    hz_ctrl_t         ctrl;

    hz_loaduse_detect u_luh (
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_uses_rs1_i    (id_uses_rs1),
        .id_uses_rs2_i    (id_uses_rs2),
        .ex_writeregsel_i (ex_writeregsel),
        .ex_mem_read_i    (ex_memRead),
        .luh_o            (luh)
    );

    // State, watchdog counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: enter on a special op, leave on ack or watchdog expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (!ex_redirect && ex_special) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            WAIT_ACK: begin
                if (periph_ack) begin
                    state_d = DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline controls; forced low while reset is held so req drops at once.
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            IDLE: begin
                if (ex_redirect) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (ex_special) begin
                    ctrl.periph_req = 1'b1;
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_hold  = 1'b1;
                end else if (luh) begin
                    ctrl.pc_hold    = 1'b1;
                    ctrl.ifid_hold  = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end
            end
            WAIT_ACK: begin
                ctrl.periph_req = 1'b1;
                ctrl.pc_hold    = 1'b1;
                ctrl.ifid_hold  = 1'b1;
                ctrl.idex_hold  = 1'b1;
            end
            DRAIN:   ctrl.idex_flush = 1'b1;
            default: ctrl = '0;
        endcase
        if (!rst) begin
            ctrl = '0;
        end
    end

    assign pc_hold    = ctrl.pc_hold;
    assign ifid_hold  = ctrl.ifid_hold;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_hold  = ctrl.idex_hold;
    assign idex_flush = ctrl.idex_flush;
    assign periph_req = ctrl.periph_req;
    assign periph_err = err_q;
    assign busy       = (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of stall cycles and flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ctrl.pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((ctrl.ifid_flush || ctrl.idex_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_writeregsel;
    logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_redirect, ex_special, periph_ack;
    logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, periph_req, periph_err, busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_writeregsel (ex_writeregsel),
        .ex_memRead     (ex_memRead),
        .ex_redirect    (ex_redirect),
        .ex_special     (ex_special),
        .periph_ack     (periph_ack),
        .pc_hold        (pc_hold),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_hold      (idex_hold),
        .idex_flush     (idex_flush),
        .periph_req     (periph_req),
        .periph_err     (periph_err),
        .busy           (busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int req_cnt  = 0;

    // Model: waiting on the peripheral, cycles waited, one drain cycle, sticky error.
    bit m_wait  = 1'b0;
    bit m_drain = 1'b0;
    bit m_err   = 1'b0;
    int m_waited = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected {pc_hold,ifid_hold,ifid_flush,idex_hold,idex_flush,periph_req,periph_err,busy}.
    function automatic logic [7:0] expect_outs();
        logic       hit;
        logic [7:0] e;
        if (!rst) return 8'h00;
        hit = ex_memRead && (ex_writeregsel != 5'd0) &&
              ((id_uses_rs1 && id_rs1 == ex_writeregsel) || (id_uses_rs2 && id_rs2 == ex_writeregsel));
        e = 8'h00;
        if (m_wait)            e[7:2] = 6'b110101;
        else if (m_drain)      e[7:2] = 6'b000010;
        else if (ex_redirect)  e[7:2] = 6'b001010;
        else if (ex_special)   e[7:2] = 6'b110101;
        else if (hit)          e[7:2] = 6'b110010;
        e[1] = m_err;
        e[0] = m_wait || m_drain;
        return e;
    endfunction

    task automatic model_adv();
        if (m_wait) begin
            if (periph_ack) begin
                m_wait = 1'b0; m_drain = 1'b1;
            end else begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_err = 1'b1; m_wait = 1'b0; m_drain = 1'b1;
                end
            end
        end else if (m_drain) begin
            m_drain = 1'b0;
        end else if (!ex_redirect && ex_special) begin
            m_wait = 1'b1; m_waited = 0;
        end
    endtask

    task automatic drive(input logic redir, input logic spec, input logic mrd, input logic [4:0] wr,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2,
                         input logic ack);
        ex_redirect = redir; ex_special = spec; ex_memRead = mrd; ex_writeregsel = wr;
        id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2; periph_ack = ack;
    endtask

    // Check this cycle's outputs, advance the model, move to the next cycle.
    task automatic step(input string tag);
        logic [7:0] got, exp;
        #1;
        got = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, periph_req, periph_err, busy};
        exp = expect_outs();
        check(tag, 32'(got), 32'(exp));
        if (periph_req) req_cnt++;
        if (exp[7]) m_stall++;
        if (exp[5] || exp[3]) m_flush++;
        model_adv();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1);
        @(negedge clk);
        step("reset_outs");
        rst = 1'b1;

        drive(0, 0, 1, 5'd5, 5'd5, 5'd9, 1, 0, 0);
        step("luh_rs1");
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("luh_after");
        drive(0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0);
        step("luh_rs2");
        drive(0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0, 0);
        step("no_use");
        drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        step("x0_load");
        drive(1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
        step("redir_luh");
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("redir_after");

        // Special op acknowledged four cycles after issue.
        req_cnt = 0;
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("spec_req");
        periph_ack = 1'b1;
        step("spec_ack");
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("spec_drain");
        step("spec_idle");
        check("spec_req_cycles", 32'(req_cnt), 32'd5);

        // No ack: watchdog expires after TMO waiting cycles; later ack is stray.
        req_cnt = 0;
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int i = 0; i < TMO + 1; i++) step("tmo_wait");
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("tmo_drain");
        periph_ack = 1'b1;
        step("tmo_stray_ack");
        periph_ack = 1'b0;
        step("tmo_idle");
        check("tmo_req_cycles", 32'(req_cnt), 32'(TMO + 1));
        check("tmo_err", 32'(periph_err), 32'd1);

        // Random traffic; redirect and special kept mutually exclusive.
        for (int i = 0; i < 1500; i++) begin
            ex_redirect    = ($urandom_range(0, 7) == 0);
            ex_special     = !ex_redirect && ($urandom_range(0, 5) == 0);
            ex_memRead     = $urandom_range(0, 1) == 1;
            ex_writeregsel = 5'($urandom_range(0, 3));
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_uses_rs1    = $urandom_range(0, 1) == 1;
            id_uses_rs2    = $urandom_range(0, 1) == 1;
            periph_ack     = ($urandom_range(0, 5) == 0);
            step("random");
        end

`ifdef HAZARD_PERF_CNT_EN
        #1;
        check("perf_stall", perf_stall_cnt, 32'(m_stall));
        check("perf_flush", perf_flush_cnt, 32'(m_flush));
`endif

        // Asynchronous reset while waiting on the peripheral.
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step("pre_rst_issue");
        step("pre_rst_wait");
        #2 rst = 1'b0;
        #1;
        check("rst_async",
              32'({pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, periph_req, periph_err, busy}),
              32'd0);
        m_wait = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_waited = 0;
        @(negedge clk);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        rst = 1'b1;
        step("post_rst_idle");
        drive(0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0);
        step("post_rst_luh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
